// File: rtl/jtkicker_psg_if.sv
// CPU write interface for a SN76489-style PSG: edge-detected write strobe, latch/data byte decode
// and register file. Define JTKICKER_PSG_BUSY_EN to add the post-write BUSY period with ready/ovf.
module jtkicker_psg_if #(
    parameter int BUSY_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       ce_n,
    input  logic       wr_n,
    input  logic [7:0] din,
    output logic       ready,
    output logic [9:0] tone0,
    output logic [9:0] tone1,
    output logic [9:0] tone2,
    output logic [3:0] vol0,
    output logic [3:0] vol1,
    output logic [3:0] vol2,
    output logic [3:0] vol3,
    output logic [2:0] noise_ctl,
    output logic       noise_rst,
    output logic       ovf
);

    logic       stb_q;
    logic       stb_dly_q;
    logic       wr_event;
    logic       accept;
    logic [2:0] sel;
    logic [2:0] idx_q,   idx_d;
    logic [9:0] tone_q  [3];
    logic [9:0] tone_d  [3];
    logic [3:0] vol_q   [4];
    logic [3:0] vol_d   [4];
    logic [2:0] noise_q, noise_d;
    logic       noise_rst_q, noise_rst_d;

    // A write event is the first cycle the registered strobe is seen high.
    assign wr_event = stb_q & ~stb_dly_q;

`ifdef JTKICKER_PSG_BUSY_EN
    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] cnt_q,   cnt_d;
    logic       ovf_q,   ovf_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_event) begin
                    accept  = 1'b1;
                    state_d = S_BUSY;
                    cnt_d   = BUSY_CYCLES[5:0];
                end
            end
            S_BUSY: begin
                if (wr_event) ovf_d = 1'b1;
                if (clk_en) begin
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign ovf   = ovf_q;
`else
    logic unused_cfg;

    assign accept     = wr_event;
    assign ready      = 1'b1;
    assign ovf        = 1'b0;
    assign unused_cfg = ^{clk_en, BUSY_CYCLES[5:0]};
`endif

    // Latch bytes select the register; data bytes reuse the last selection.
    always_comb begin
        idx_d       = idx_q;
        tone_d      = tone_q;
        vol_d       = vol_q;
        noise_d     = noise_q;
        noise_rst_d = 1'b0;
        sel         = din[7] ? din[6:4] : idx_q;
        if (accept) begin
            if (din[7]) idx_d = din[6:4];
            case (sel)
                3'd0, 3'd2, 3'd4: begin
                    if (din[7]) tone_d[sel[2:1]] = {tone_q[sel[2:1]][9:4], din[3:0]};
                    else        tone_d[sel[2:1]] = {din[5:0], tone_q[sel[2:1]][3:0]};
                end
                3'd6: begin
                    noise_d     = din[2:0];
                    noise_rst_d = 1'b1;
                end
                default: vol_d[sel[2:1]] = din[3:0];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stb_q       <= 1'b0;
            stb_dly_q   <= 1'b0;
            idx_q       <= 3'd0;
            tone_q      <= '{default: 10'd0};
            vol_q       <= '{default: 4'hF};
            noise_q     <= 3'd0;
            noise_rst_q <= 1'b0;
        end else begin
            stb_q       <= ~ce_n & ~wr_n;
            stb_dly_q   <= stb_q;
            idx_q       <= idx_d;
            tone_q      <= tone_d;
            vol_q       <= vol_d;
            noise_q     <= noise_d;
            noise_rst_q <= noise_rst_d;
        end
    end

    assign tone0     = tone_q[0];
    assign tone1     = tone_q[1];
    assign tone2     = tone_q[2];
    assign vol0      = vol_q[0];
    assign vol1      = vol_q[1];
    assign vol2      = vol_q[2];
    assign vol3      = vol_q[3];
    assign noise_ctl = noise_q;
    assign noise_rst = noise_rst_q;

endmodule
